cim_result_packer: RTL and testbench

- Downstream consumer of the CIM adder-tree stage.
- Takes each 13-bit accumulated column result, delivered with a one-cycle valid pulse.
- Requantizes it to 8 bits with rounding and saturation.
- Packs LANES results into one word and buffers the words in a small FIFO toward the memory writer, using a valid/ready handshake.

---
 rtl/cim_result_packer.sv | 203 ++++++++++++++++++++
 tb/tb_cim_result_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_result_packer.sv
// Requantizes adder-tree results to OUT_W bits, packs LANES of them per word and queues words in a small FIFO.
// Optional statistics counters (res_cnt, drop_cnt) are enabled by defining CIM_PACK_STATS_EN.
module cim_result_packer #(
    parameter int unsigned IN_W       = 13,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [IN_W-1:0]                  in_data,
    input  logic                             flush,
    input  logic                             clr_ovf,
    output logic                             m_valid,
    output logic [LANES*OUT_W-1:0]           m_data,
    output logic [$clog2(LANES+1)-1:0]       m_count,
    input  logic                             m_ready,
    output logic                             ovf,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
`ifdef CIM_PACK_STATS_EN
    ,
    output logic [15:0]                      res_cnt,
    output logic [15:0]                      drop_cnt
`endif
);

    localparam int unsigned SW = IN_W + 1;
    localparam int unsigned DW = LANES * OUT_W;
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] MAXQ = SW'((1 << OUT_W) - 1);

    logic [SW-1:0]    sum_c;
    logic [SW-1:0]    shifted_c;
    logic [OUT_W-1:0] q_c;

    logic [OUT_W-1:0] pack_q [LANES];
    logic [OUT_W-1:0] pack_d [LANES];
    logic [CW-1:0]    lane_q, lane_d;
    logic [DW-1:0]    mem_q  [FIFO_DEPTH];
    logic [DW-1:0]    mem_d  [FIFO_DEPTH];
    logic [CW-1:0]    cmem_q [FIFO_DEPTH];
    logic [CW-1:0]    cmem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             m_valid_q, m_valid_d;
    logic [DW-1:0]    m_data_q, m_data_d;
    logic [CW-1:0]    m_count_q, m_count_d;
    logic             ovf_q, ovf_d;

    logic [DW-1:0]    word_c;
    logic [CW-1:0]    cnt_after_c;
    logic             push_c, pop_c, full_c, accept_c, drop_c;

    // Rounding offset only exists for a non-zero shift.
    generate
        if (SHIFT > 0) begin : g_round
            assign sum_c = {1'b0, in_data} + SW'(1 << (SHIFT - 1));
        end else begin : g_noround
            assign sum_c = {1'b0, in_data};
        end
    endgenerate

    always_comb begin
        shifted_c = sum_c >> SHIFT;
        if (shifted_c > MAXQ) begin
            q_c = '1;
        end else begin
            q_c = shifted_c[OUT_W-1:0];
        end
    end

    // Pack register with the current result merged into its lane.
    always_comb begin
        word_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid && (lane_q == CW'(i))) begin
                word_c[i*OUT_W +: OUT_W] = q_c;
            end else begin
                word_c[i*OUT_W +: OUT_W] = pack_q[i];
            end
        end
    end

    always_comb begin
        lane_d    = lane_q;
        pack_d    = pack_q;
        mem_d     = mem_q;
        cmem_d    = cmem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q & ~clr_ovf;

        cnt_after_c = lane_q + CW'(in_valid);
        push_c      = (cnt_after_c == CW'(LANES)) || (flush && (cnt_after_c != '0));
        pop_c       = m_valid_q && m_ready;
        full_c      = (level_q == LW'(FIFO_DEPTH));
        accept_c    = push_c && (!full_c || pop_c);
        drop_c      = push_c && full_c && !pop_c;

        if (push_c) begin
            lane_d = '0;
            for (int i = 0; i < LANES; i++) begin
                pack_d[i] = '0;
            end
        end else begin
            lane_d = cnt_after_c;
            for (int i = 0; i < LANES; i++) begin
                pack_d[i] = word_c[i*OUT_W +: OUT_W];
            end
        end

        if (accept_c) begin
            mem_d[wr_ptr_q]  = word_c;
            cmem_d[wr_ptr_q] = cnt_after_c;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({accept_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop_c) begin
            ovf_d = 1'b1;
        end

        // Head outputs are registered copies of the next-state head entry.
        m_valid_d = (level_d != '0);
        m_data_d  = mem_d[rd_ptr_d];
        m_count_d = cmem_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                pack_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i]  <= '0;
                cmem_q[i] <= '0;
            end
            lane_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pack_q    <= pack_d;
            mem_q     <= mem_d;
            cmem_q    <= cmem_d;
            lane_q    <= lane_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_count    = m_count_q;
    assign ovf        = ovf_q;
    assign fifo_level = level_q;

`ifdef CIM_PACK_STATS_EN
    logic [15:0] res_cnt_q, res_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Free-running wrap-around counters, independent of clr_ovf.
    always_comb begin
        res_cnt_d  = res_cnt_q + 16'(in_valid);
        drop_cnt_d = drop_cnt_q + 16'(drop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            res_cnt_q  <= res_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign res_cnt  = res_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cim_result_packer.sv
// Directed and random checks of cim_result_packer against a queue-based reference model.
// Define CIM_PACK_STATS_EN to also check the statistics counters.
module tb_cim_result_packer;

    localparam int SHIFT = 2;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] in_data = '0;
    logic        flush = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_count;
    logic        m_ready = 1'b0;
    logic        ovf;
    logic [2:0]  fifo_level;
`ifdef CIM_PACK_STATS_EN
    logic [15:0] res_cnt;
    logic [15:0] drop_cnt;
`endif

    cim_result_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_count    (m_count),
        .m_ready    (m_ready),
        .ovf        (ovf),
        .fifo_level (fifo_level)
`ifdef CIM_PACK_STATS_EN
        ,
        .res_cnt    (res_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          c;
    } word_t;

    word_t fq[$];
    int    pend[$];
    bit    m_ovf;
    int    m_res;
    int    m_drop;
    int    compares;
    int    fails;

    function automatic int qz(input int d);
        int r;
        if (SHIFT == 0) r = d;
        else r = (d + (1 << (SHIFT - 1))) / (1 << SHIFT);
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        pend.delete();
        m_ovf  = 1'b0;
        m_res  = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit f, input bit c, input bit r);
        bit    pop;
        bit    drop;
        int    pre;
        word_t w;
        pre  = fq.size();
        pop  = (pre > 0) && r;
        drop = 1'b0;
        if (v) begin
            pend.push_back(qz(d));
            m_res++;
        end
        if (pop) void'(fq.pop_front());
        if (pend.size() == LANES || (f && pend.size() > 0)) begin
            w.d = '0;
            w.c = pend.size();
            foreach (pend[i]) w.d = w.d | (32'(pend[i]) << (8 * i));
            if (pre < DEPTH || pop) fq.push_back(w);
            else begin
                drop = 1'b1;
                m_drop++;
            end
            pend.delete();
        end
        m_ovf = (m_ovf && !c) || drop;
    endtask

    task automatic check_all();
        chk("m_valid", 32'(m_valid), 32'(fq.size() > 0));
        chk("fifo_level", 32'(fifo_level), 32'(fq.size()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (fq.size() > 0) begin
            chk("m_data", m_data, fq[0].d);
            chk("m_count", 32'(m_count), 32'(fq[0].c));
        end
`ifdef CIM_PACK_STATS_EN
        chk("res_cnt", 32'(res_cnt), 32'(m_res & 16'hFFFF));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop & 16'hFFFF));
`endif
    endtask

    task automatic step(input bit v, input int d, input bit f, input bit c, input bit r);
        @(negedge clk);
        in_valid = v;
        in_data  = 13'(d);
        flush    = f;
        clr_ovf  = c;
        m_ready  = r;
        model_step(v, d, f, c, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        clr_ovf  = 1'b0;
        #1;
        model_reset();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_count", 32'(m_count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
`ifdef CIM_PACK_STATS_EN
        chk("rst_res_cnt", 32'(res_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        compares = 0;
        fails    = 0;
        model_reset();
        #2;
        do_reset();

        // Basic pack
        step(1, 100, 0, 0, 1);
        step(1, 101, 0, 0, 1);
        step(1, 102, 0, 0, 1);
        step(1, 1023, 0, 0, 1);
        chk("basic_valid", 32'(m_valid), 32'd1);
        chk("basic_data", m_data, 32'hFF1A1919);
        chk("basic_count", 32'(m_count), 32'd4);
        step(0, 0, 0, 0, 1);

        // Saturation and rounding
        step(1, 8191, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(1, 2, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("sat_data", m_data, 32'h000100FF);
        step(0, 0, 0, 0, 1);

        // Flush of a partial word, then a flush with nothing pending
        step(1, 4, 0, 0, 1);
        step(1, 8, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        chk("flush_data", m_data, 32'h00000201);
        chk("flush_count", 32'(m_count), 32'd2);
        step(0, 0, 1, 0, 1);
        chk("flush_empty_valid", 32'(m_valid), 32'd0);

        // Flush coinciding with the completing result
        step(1, 40, 0, 0, 1);
        step(1, 41, 0, 0, 1);
        step(1, 42, 0, 0, 1);
        step(1, 43, 1, 0, 1);
        chk("flush4_count", 32'(m_count), 32'd4);
        step(0, 0, 0, 0, 1);
        chk("flush4_single", 32'(m_valid), 32'd0);

        // Overflow with downstream stalled
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 16 * i, 0, 0, 0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
`ifdef CIM_PACK_STATS_EN
        chk("ovf_res_cnt", 32'(res_cnt), 32'd20);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("drain_empty", 32'(m_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(ovf), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Full FIFO: stall, then simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1, 3 * i + 7, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(1, 500, 0, 0, 0);
        step(1, 600, 0, 0, 0);
        step(1, 700, 0, 0, 0);
        step(1, 800, 0, 0, 1);
        chk("pushpop_level", 32'(fifo_level), 32'd4);
        chk("pushpop_no_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

        // Reset mid-word discards partial results
        step(1, 9, 0, 0, 1);
        step(1, 10, 0, 0, 1);
        do_reset();
        step(1, 20, 0, 0, 1);
        step(1, 24, 0, 0, 1);
        step(1, 28, 0, 0, 1);
        step(1, 32, 0, 0, 1);
        chk("post_rst_data", m_data, 32'h08070605);
        step(0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int d;
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 3);
                1: d = $urandom_range(8188, 8191);
                2: d = $urandom_range(1018, 1025);
                default: d = $urandom_range(0, 8191);
            endcase
            step(($urandom_range(0, 1) == 1), d, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end

        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        clr_ovf  = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
